// File: rtl/seq_mult_n.sv
// -----------------------------------------------------------------------------
// seq_mult_n -- sequential shift-and-add multiplier, one multiplier bit per clock
//
// Purpose:
//   Multiplies two WIDTH-bit operands, either unsigned or two's complement,
//   and produces an exact 2*WIDTH-bit product. Signed operands are reduced to
//   their magnitudes on start. The unsigned product of the magnitudes is
//   accumulated through a chain of fa1 full-adder cells. The final sum is
//   negated on the way into the result register when the operand signs differ.
//
// Parameters:
//   WIDTH        operand width in bits (4..32), default 16
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous, active-high reset
//   start        begins a new multiplication (in any state, aborting any other)
//   signed_mode  1 = two's complement operands, 0 = unsigned (sampled with start)
//   a            multiplicand (sampled with start)
//   b            multiplier   (sampled with start)
//   busy         high while an operation is running
//   ready        high while a finished product is being presented
//   result       product, valid while ready is high, zero otherwise
//
// Build option:
//   SEQ_MULT_N_EARLY_TERM_EN  when defined, RUN finishes as soon as no set
//                             multiplier bits remain, so latency follows the
//                             magnitude of b. The product is the same either way.
// -----------------------------------------------------------------------------

// Single-bit full adder cell used to build the accumulator ripple chain.
module fa1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module seq_mult_n #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [PW-1:0]     reg_a;
    logic [WIDTH-1:0]  reg_b;
    logic [PW-1:0]     acc;
    logic [CNT_W-1:0]  count;
    logic              neg_flag;
    logic [PW-1:0]     result_reg;

    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic [PW-1:0]     addend;
    logic [PW-1:0]     sum;
    logic [PW:0]       carry;
    logic              carry_out_unused;
    logic              last_step;

    // Operand magnitudes. The most negative value maps to 2^(WIDTH-1), which
    // still fits in WIDTH unsigned bits, so no extra sign bit is needed.
    always_comb begin
        mag_a = a;
        mag_b = b;
        if (signed_mode && a[WIDTH-1]) begin
            mag_a = ~a + WIDTH'(1);
        end
        if (signed_mode && b[WIDTH-1]) begin
            mag_b = ~b + WIDTH'(1);
        end
    end

    // The partial product added this step is the shifted multiplicand, but
    // only when the current low multiplier bit is set.
    assign addend = reg_b[0] ? reg_a : '0;

    // Ripple-carry accumulator: carry enters at zero and the final carry out
    // is dropped, because 2*WIDTH bits already hold any magnitude product.
    assign carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_ripple
            fa1 u_fa1 (
                .a    (acc[gi]),
                .b    (addend[gi]),
                .cin  (carry[gi]),
                .sum  (sum[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign carry_out_unused = carry[PW];

    // The last RUN step is normally the one that consumes the top multiplier
    // bit. With early termination it can also be any step after which the
    // shifted-down multiplier has no set bits left.
`ifdef SEQ_MULT_N_EARLY_TERM_EN
    assign last_step = (state == RUN) &&
                       ((count == CNT_W'(WIDTH - 1)) || (reg_b[WIDTH-1:1] == '0));
`else
    assign last_step = (state == RUN) && (count == CNT_W'(WIDTH - 1));
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A start request overrides every state, so a running
    // or finished operation is simply abandoned in favour of the new one.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (last_step) begin
                        state_next = DONE;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    // Datapath. Start loads the magnitudes and clears the accumulator, the
    // step count and the result. Each RUN cycle then does one add and shift.
    // The signed result is formed only once, on the final step, so
    // intermediate sums stay plain unsigned. Outside RUN and start,
    // everything holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_a      <= '0;
            reg_b      <= '0;
            acc        <= '0;
            count      <= '0;
            neg_flag   <= 1'b0;
            result_reg <= '0;
        end else if (start) begin
            reg_a      <= {{WIDTH{1'b0}}, mag_a};
            reg_b      <= mag_b;
            acc        <= '0;
            count      <= '0;
            neg_flag   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            result_reg <= '0;
        end else if (state == RUN) begin
            acc   <= sum;
            reg_a <= reg_a << 1;
            reg_b <= reg_b >> 1;
            count <= count + CNT_W'(1);
            if (last_step) begin
                result_reg <= neg_flag ? (~sum + PW'(1)) : sum;
            end
        end
    end

    assign busy   = (state == RUN);
    assign ready  = (state == DONE);
    assign result = ready ? result_reg : '0;

endmodule

// File: tb/tb_seq_mult_n.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_n -- self-checking bench for seq_mult_n at WIDTH=16
//
// Products and latencies come from arithmetic on the operand values. Products
// use full-width integer multiplication. Latencies come from the bit length of
// the multiplier magnitude when early termination is built in.
// -----------------------------------------------------------------------------
module tb_seq_mult_n;

    localparam int W = 16;

`ifdef SEQ_MULT_N_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            signed_mode;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            busy;
    logic            ready;
    logic [2*W-1:0]  result;

    int checks   = 0;
    int failures = 0;

    seq_mult_n #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .ready       (ready),
        .result      (result)
    );

    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Exact product of the operands as integers, truncated to 2*W bits.
    function automatic logic [2*W-1:0] model_product(input logic [W-1:0] op_a,
                                                     input logic [W-1:0] op_b,
                                                     input logic sm);
        longint pa;
        longint pb;
        longint p;
        if (sm) begin
            pa = longint'($signed(op_a));
            pb = longint'($signed(op_b));
        end else begin
            pa = longint'(op_a);
            pb = longint'(op_b);
        end
        p = pa * pb;
        return p[2*W-1:0];
    endfunction

    // Cycles from the start edge to ready: W normally. With early termination
    // it is the bit length of |b|, at least 1.
    function automatic int model_latency(input logic [W-1:0] op_b, input logic sm);
        longint v;
        int     bits;
        v = sm ? longint'($signed(op_b)) : longint'(op_b);
        if (v < 0) v = -v;
        bits = 0;
        for (int i = 0; i <= W; i++) begin
            if ((v >> i) != 0) bits = i + 1;
        end
        if (bits < 1) bits = 1;
        return EARLY_TERM ? bits : W;
    endfunction

    // Presents operands with start for exactly one rising edge (edge k) and
    // returns 1 time unit after it.
    task automatic start_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                            input logic sm);
        @(negedge clk);
        a           = op_a;
        b           = op_b;
        signed_mode = sm;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the start edge until ready, bounded.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (ready !== 1'b1 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        signed_mode = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, ready, result} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_state: busy=%0b ready=%0b result=%h expected all 0",
                     busy, ready, result);
        end
        // start must be ignored while reset is held
        start = 1'b1;
        a = 16'd5;
        b = 16'd6;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL start_during_reset: busy=%0b expected 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, ready} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: busy=%0b ready=%0b expected 0 0", busy, ready);
        end
    endtask

    task automatic test_unsigned_max();
        int cycles;
        int busy_cycles;
        start_op(16'hFFFF, 16'hFFFF, 1'b0);
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        cycles = 0;
        while (ready !== 1'b1 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy === 1'b1) busy_cycles++;
        end
        checks++;
        if (cycles != 16) begin
            failures++;
            $display("[TB] FAIL umax_latency: got %0d edges expected 16", cycles);
        end
        checks++;
        if (result !== 32'hFFFE0001) begin
            failures++;
            $display("[TB] FAIL umax_result: got %h expected fffe0001", result);
        end
        checks++;
        if (busy_cycles != 16 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL umax_busy: busy cycles %0d (busy now %0b) expected 16 (0)",
                     busy_cycles, busy);
        end
    endtask

    task automatic test_signed();
        int cycles;
        start_op(16'hFFFD, 16'h0005, 1'b1);
        wait_ready(cycles);
        checks++;
        if (cycles != model_latency(16'h0005, 1'b1) || result !== 32'hFFFFFFF1) begin
            failures++;
            $display("[TB] FAIL signed_neg3x5: lat %0d result %h expected lat %0d result fffffff1",
                     cycles, result, model_latency(16'h0005, 1'b1));
        end
        start_op(16'h8000, 16'h8000, 1'b1);
        wait_ready(cycles);
        checks++;
        if (cycles != 16 || result !== 32'h40000000) begin
            failures++;
            $display("[TB] FAIL signed_minxmin: lat %0d result %h expected lat 16 result 40000000",
                     cycles, result);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] corners [5];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         sm;
        int           cycles;
        corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : W'($urandom);
            sm = 1'($urandom_range(0, 1));
            start_op(ra, rb, sm);
            wait_ready(cycles);
            checks++;
            if (cycles != model_latency(rb, sm) || result !== model_product(ra, rb, sm)) begin
                failures++;
                $display("[TB] FAIL random_op a=%h b=%h s=%0b: lat %0d result %h expected lat %0d result %h",
                         ra, rb, sm, cycles, result, model_latency(rb, sm),
                         model_product(ra, rb, sm));
            end
        end
    endtask

    task automatic test_restart();
        int cycles;
        bit early_ready;
        early_ready = 1'b0;
        start_op(16'd100, 16'd200, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) early_ready = 1'b1;
        end
        start_op(16'd7, 16'd9, 1'b0);
        wait_ready(cycles);
        checks++;
        if (early_ready || cycles != model_latency(16'd9, 1'b0)) begin
            failures++;
            $display("[TB] FAIL restart_latency: early ready %0b, lat %0d expected no early ready, lat %0d",
                     early_ready, cycles, model_latency(16'd9, 1'b0));
        end
        checks++;
        if (result !== 32'd63) begin
            failures++;
            $display("[TB] FAIL restart_result: got %0d expected 63", result);
        end
    endtask

    task automatic test_reset_mid();
        int cycles;
        int bad;
        start_op(16'hFFFF, 16'hFFFF, 1'b0);
        repeat (8) @(posedge clk);
        #3;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midop_busy: busy=%0b expected 1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, ready, result} !== '0) begin
            failures++;
            $display("[TB] FAIL midop_async_reset: busy=%0b ready=%0b result=%h expected all 0",
                     busy, ready, result);
        end
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if ({busy, ready, result} !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL midop_no_ready: %0d nonzero cycles after release, expected 0", bad);
        end
        start_op(16'd3, 16'd4, 1'b0);
        wait_ready(cycles);
        checks++;
        if (cycles != model_latency(16'd4, 1'b0) || result !== 32'd12) begin
            failures++;
            $display("[TB] FAIL first_after_reset: lat %0d result %0d expected lat %0d result 12",
                     cycles, result, model_latency(16'd4, 1'b0));
        end
    endtask

    task automatic test_hold();
        logic [W-1:0]   ha;
        logic [W-1:0]   hb;
        logic [2*W-1:0] expected;
        int             cycles;
        int             bad;
        ha = W'($urandom);
        hb = W'($urandom);
        expected = model_product(ha, hb, 1'b1);
        start_op(ha, hb, 1'b1);
        wait_ready(cycles);
        checks++;
        if (result !== expected) begin
            failures++;
            $display("[TB] FAIL hold_initial: got %h expected %h", result, expected);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
            signed_mode = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (ready !== 1'b1 || result !== expected) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL hold_stable: %0d cycles changed, expected 0 (result %h)", bad, result);
        end
        start_op(16'd11, 16'd13, 1'b0);
        checks++;
        if (ready !== 1'b0 || result !== '0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL leave_done: ready=%0b result=%h busy=%0b expected 0 0 1",
                     ready, result, busy);
        end
        wait_ready(cycles);
        checks++;
        if (result !== 32'd143) begin
            failures++;
            $display("[TB] FAIL back_to_back: got %0d expected 143", result);
        end
    endtask

    task automatic test_early_term();
        int cycles;
        int expected_lat;
        expected_lat = EARLY_TERM ? 1 : 16;
        start_op(16'd1234, 16'd1, 1'b0);
        wait_ready(cycles);
        checks++;
        if (cycles != expected_lat) begin
            failures++;
            $display("[TB] FAIL early_term_latency: got %0d expected %0d", cycles, expected_lat);
        end
        checks++;
        if (result !== 32'd1234) begin
            failures++;
            $display("[TB] FAIL early_term_result: got %0d expected 1234", result);
        end
        start_op(16'd4321, 16'd0, 1'b1);
        wait_ready(cycles);
        checks++;
        if (cycles != (EARLY_TERM ? 1 : 16) || result !== '0) begin
            failures++;
            $display("[TB] FAIL zero_multiplier: lat %0d result %h expected lat %0d result 0",
                     cycles, result, EARLY_TERM ? 1 : 16);
        end
    endtask

    initial begin
        $display("[TB] seq_mult_n bench, WIDTH=%0d, early termination=%0b", W, EARLY_TERM);
        test_reset();
        test_unsigned_max();
        test_signed();
        test_random();
        test_restart();
        test_reset_mid();
        test_hold();
        test_early_term();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_mult_n.md
SEQ_MULT_N -- requirements
Module: seq_mult_n

Interface
REQ-001: Parameter WIDTH, default 16, operand width in bits; legal range 4..32.
REQ-002: Port clk  input  1  clock; all state updates on rising edge.
REQ-003: Port reset  input  1  reset, asynchronous, active-high.
REQ-004: Port start  input  1  synchronous request; when high on a clk posedge, begins a new multiplication.
REQ-005: Port signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; sampled with start.
REQ-006: Port a  input  WIDTH  multiplicand; sampled with start.
REQ-007: Port b  input  WIDTH  multiplier; sampled with start.
REQ-008: Port busy  output  1  high while the block is in RUN.
REQ-009: Port ready  output  1  high while the block is in DONE.
REQ-010: Port result  output  2*WIDTH  product; valid when ready=1, else 0.

Function
REQ-011: FSM states: IDLE, RUN, DONE; busy=(state==RUN), ready=(state==DONE).
REQ-012: start=1 on posedge in any state -> load operands, clear accumulator, count=0, state=RUN; an in-flight or completed operation is discarded.
REQ-013: In signed mode, the operand registers hold |a| and |b| (WIDTH-bit unsigned; |-2^(WIDTH-1)| = 2^(WIDTH-1)), and neg_flag = a[msb] XOR b[msb]; in unsigned mode, neg_flag=0.
REQ-014: Each RUN posedge (start=0): if reg_b[0], accumulator += reg_a; then reg_a <<= 1 (2*WIDTH bits), reg_b >>= 1, count += 1.
REQ-015: Accumulation uses the team's FA1-based ripple adder chained to 2*WIDTH bits, with carry-in 0 and carry-out discarded.
REQ-016: The RUN posedge with count==WIDTH-1 is the last step: state -> DONE, and result is registered as the final sum, two's-complement negated if neg_flag=1.
REQ-017: Latency: start sampled at edge k -> ready=1 and result valid after edge k+WIDTH.
REQ-018: DONE holds ready and result stable until the next start posedge or reset.
REQ-019: The start edge that leaves DONE drops ready and clears result to 0 after that edge.
REQ-020: In IDLE and DONE with start=0, operand and accumulator registers hold their values.
REQ-021: The product is exact for all inputs; 2*WIDTH bits cover both the unsigned maximum and (-2^(WIDTH-1))^2.

Reset
REQ-022: reset=1 asynchronously forces state=IDLE, busy=0, ready=0, result=0, count=0 and clears accumulator, reg_a, reg_b and neg_flag.
REQ-023: Reset during RUN aborts the operation; no ready pulse follows.
REQ-024: The first start after reset deasserts behaves per REQ-012.
REQ-025: start is ignored while reset=1.

Configuration
REQ-026: Macro SEQ_MULT_N_EARLY_TERM_EN, when defined, ends RUN early: a RUN posedge is also the last step when (reg_b>>1)==0 after its add, with DONE behaviour per REQ-016.
REQ-027: With SEQ_MULT_N_EARLY_TERM_EN defined, latency is k+max(1, index of the highest set bit of the multiplier magnitude + 1); b=0 -> ready after edge k+1.
REQ-028: Without the macro, latency is always k+WIDTH; results are identical in both builds.

Verification (WIDTH=16)
REQ-029: Unsigned: a=0xFFFF, b=0xFFFF, start at edge k -> ready=1 after edge k+16, result=0xFFFE0001; busy=1 for edges k..k+15.
REQ-030: Signed: a=0xFFFD (-3), b=0x0005 -> result=0xFFFFFFF1; then a=0x8000, b=0x8000 -> result=0x40000000.
REQ-031: Restart: start 100*200, re-start at edge k+5 with 7*9 -> ready only after edge k+5+16, result=63, no earlier ready.
REQ-032: Reset mid-op: assert reset asynchronously at RUN count=8 -> busy, ready and result go to 0 immediately and stay 0 after release until a new start.
REQ-033: Hold: after DONE, hold start=0 for 20 cycles while toggling a and b -> ready and result stay constant; the next start drops ready after one edge.
REQ-034: SEQ_MULT_N_EARLY_TERM_EN: a=1234, b=1 -> ready after edge k+1, result=1234; without the macro -> ready after k+16, same result.
